peak_detect: RTL and testbench
==============================

PEAK_DETECT -- requirements
Module: peak_detect

Interface
REQ-001 Parameter DATA_WIDTH, 16, width of din, thresh and peak_value.
REQ-002 Parameter NUM_CHANNELS, 1, number of time-interleaved channels on din, legal range 1..256.
REQ-003 Parameter WINDOW_LENGTH, 64, samples per channel per detection window, legal range 2..65536.
REQ-004 Derived widths SHALL be CW = max(1, log2(NUM_CHANNELS-1)) and IW = max(1, log2(WINDOW_LENGTH-1)), using the codebase log2 function.
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 ena  input  1  active-high sample strobe; din is consumed only when ena=1.
REQ-008 din  input  DATA_WIDTH  unsigned sample stream, channel-interleaved 0,1,..,NUM_CHANNELS-1,0,.. (boxcar filter output).
REQ-009 thresh  input  DATA_WIDTH  unsigned detection threshold; may change at any time.
REQ-010 peak_valid  output  1  one-cycle pulse, registered; qualifies peak_* outputs.
REQ-011 peak_chan  output  CW  channel of the reported result.
REQ-012 peak_index  output  IW  sample index (0..WINDOW_LENGTH-1) of the maximum within the window.
REQ-013 peak_value  output  DATA_WIDTH  maximum sample value within the window.
REQ-014 peak_hit  output  1  peak_value >= thresh, thresh sampled on the emitting cycle.

Function
REQ-015 Channel counter SHALL advance 0..NUM_CHANNELS-1 on each ena and wrap to 0; it SHALL hold when ena=0.
REQ-016 Sample counter SHALL advance 0..WINDOW_LENGTH-1 when channel counter wraps, and wrap to 0 after WINDOW_LENGTH-1.
REQ-017 Per channel, state SHALL hold the running maximum (value, index); comparison unsigned, update only on strictly greater, so ties keep the earliest index.
REQ-018 At sample index 0 for a channel, the running maximum SHALL be loaded unconditionally with din and index 0 (no carry-over between windows).
REQ-019 When ena=1 at sample index WINDOW_LENGTH-1 for channel c, the next cycle SHALL show peak_valid=1, peak_chan=c, and value/index = max over the window including that final sample.
REQ-020 Latency SHALL be exactly 1 cycle from the enabled final sample to peak_valid; with NUM_CHANNELS>1 and consecutive ena, one result per channel SHALL emit on consecutive cycles.
REQ-021 peak_valid SHALL be 0 on every cycle not covered by REQ-019; peak_chan/peak_index/peak_value/peak_hit SHALL hold their last values while peak_valid=0.
REQ-022 peak_hit SHALL compare the emitted peak_value against thresh presented on the final-sample cycle.
REQ-023 ena gaps of any length SHALL not alter results; counters and maxima freeze while ena=0.
REQ-024 No arithmetic is performed on din; no overflow is possible.
REQ-025 Per-channel state MAY be registers or RAM; result SHALL be identical either way.

Reset
REQ-026 rst=1 SHALL clear both counters, all per-channel maxima and indices, peak_valid, peak_chan, peak_index, peak_value, peak_hit to 0 on the next edge.
REQ-027 rst SHALL take priority over ena; the first enabled sample after rst deasserts is channel 0, index 0.
REQ-028 rst mid-window SHALL discard the partial window; no peak_valid SHALL be emitted for it.
REQ-029 Power-up register values SHALL equal reset values.

Verification
REQ-030 NC=1, WL=4, thresh=10, ena continuous, din 3,9,7,9 -> one cycle after 4th sample: peak_valid=1, value=9, index=1, hit=0.
REQ-031 NC=2, WL=2, din 5,1,8,2 -> two consecutive pulses: (chan0, value 8, index 1), then (chan1, value 2, index 1).
REQ-032 NC=1, WL=4, din 20,0,0,0, thresh=20 -> value=20, index=0, hit=1; following window 1,2,3,4 -> value=4, index=3 (no carry-over).
REQ-033 Same as REQ-030 with ena=0 for 5 cycles between each sample -> identical result, pulse 1 cycle after final enabled sample, no extra pulses.
REQ-034 rst asserted after 2 of 4 samples, then 4 samples 1,2,3,4 -> no pulse for the partial window; single pulse value=4, index=3, chan=0.
REQ-035 NC=3, WL=2, thresh changed from 0 to 0xFFFF on the final sample cycle of chan1 -> chan0 hit=1, chan1 and chan2 hit=0.

Source files
------------

// File: rtl/peak_detect.sv
`default_nettype none
// ============================================================================
//  Module   : peak_detect
//  Purpose  : Per-channel windowed maximum (value + index) detector with
//             threshold flag over a channel-interleaved sample stream.
//  Revision : 1.0
// ============================================================================
module peak_detect #(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_CHANNELS  = 1,
    parameter int WINDOW_LENGTH = 64,
    // Bit count needed to hold N-1, never less than 1
    localparam int CW = (NUM_CHANNELS  > 1) ? $clog2(NUM_CHANNELS)  : 1,
    localparam int IW = (WINDOW_LENGTH > 1) ? $clog2(WINDOW_LENGTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] thresh,
    output logic                  peak_valid,
    output logic [CW-1:0]         peak_chan,
    output logic [IW-1:0]         peak_index,
    output logic [DATA_WIDTH-1:0] peak_value,
    output logic                  peak_hit
);

    localparam logic [CW-1:0] c_last_chan = CW'(NUM_CHANNELS - 1);
    localparam logic [IW-1:0] c_last_samp = IW'(WINDOW_LENGTH - 1);

    logic [CW-1:0]         r_chan;
    logic [IW-1:0]         r_samp;
    logic [DATA_WIDTH-1:0] r_max_val [NUM_CHANNELS];
    logic [IW-1:0]         r_max_idx [NUM_CHANNELS];

    logic                  r_valid;
    logic [CW-1:0]         r_peak_chan;
    logic [IW-1:0]         r_peak_index;
    logic [DATA_WIDTH-1:0] r_peak_value;
    logic                  r_peak_hit;

    logic [DATA_WIDTH-1:0] w_cur_val;
    logic [IW-1:0]         w_cur_idx;
    logic                  w_take;
    logic [DATA_WIDTH-1:0] w_new_val;
    logic [IW-1:0]         w_new_idx;
    logic                  w_last_chan;
    logic                  w_last_samp;

    // Index 0 reloads unconditionally so no maximum survives into the next window;
    // strict greater-than keeps the earliest index on ties.
    always_comb begin
        w_cur_val   = r_max_val[r_chan];
        w_cur_idx   = r_max_idx[r_chan];
        w_take      = (r_samp == '0) || (din > w_cur_val);
        w_new_val   = w_take ? din    : w_cur_val;
        w_new_idx   = w_take ? r_samp : w_cur_idx;
        w_last_chan = (r_chan == c_last_chan);
        w_last_samp = (r_samp == c_last_samp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chan       <= '0;
            r_samp       <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_max_val[i] <= '0;
                r_max_idx[i] <= '0;
            end
            r_valid      <= 1'b0;
            r_peak_chan  <= '0;
            r_peak_index <= '0;
            r_peak_value <= '0;
            r_peak_hit   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (ena) begin
                r_max_val[r_chan] <= w_new_val;
                r_max_idx[r_chan] <= w_new_idx;
                if (w_last_samp) begin
                    r_valid      <= 1'b1;
                    r_peak_chan  <= r_chan;
                    r_peak_index <= w_new_idx;
                    r_peak_value <= w_new_val;
                    r_peak_hit   <= (w_new_val >= thresh);
                end
                if (w_last_chan) begin
                    r_chan <= '0;
                    r_samp <= w_last_samp ? '0 : r_samp + 1'b1;
                end else begin
                    r_chan <= r_chan + 1'b1;
                end
            end
        end
    end

    assign peak_valid = r_valid;
    assign peak_chan  = r_peak_chan;
    assign peak_index = r_peak_index;
    assign peak_value = r_peak_value;
    assign peak_hit   = r_peak_hit;

endmodule
`default_nettype wire

// File: tb/tb_peak_detect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_peak_detect
//  Purpose  : Directed scoreboard bench for peak_detect on three configurations.
//  Revision : 1.0
// ============================================================================
module tb_peak_detect;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int neg_cnt = 0;
    bit mon_en  = 1'b0;

    typedef struct {
        int due;
        int chan;
        int idx;
        int val;
        int hit;
    } exp_t;

    exp_t q_a[$], q_b[$], q_c[$];
    exp_t l_a, l_b, l_c;

    // A: NC=1 WL=4, B: NC=2 WL=2, C: NC=3 WL=2
    logic        a_rst, a_ena, a_valid, a_hit;
    logic [15:0] a_din, a_thr, a_val;
    logic [0:0]  a_chan;
    logic [1:0]  a_idx;

    logic        b_rst, b_ena, b_valid, b_hit;
    logic [15:0] b_din, b_thr, b_val;
    logic [0:0]  b_chan;
    logic [0:0]  b_idx;

    logic        c_rst, c_ena, c_valid, c_hit;
    logic [15:0] c_din, c_thr, c_val;
    logic [1:0]  c_chan;
    logic [0:0]  c_idx;

    peak_detect #(.DATA_WIDTH(16), .NUM_CHANNELS(1), .WINDOW_LENGTH(4)) u_a (
        .clk(clk), .rst(a_rst), .ena(a_ena), .din(a_din), .thresh(a_thr),
        .peak_valid(a_valid), .peak_chan(a_chan), .peak_index(a_idx),
        .peak_value(a_val), .peak_hit(a_hit)
    );

    peak_detect #(.DATA_WIDTH(16), .NUM_CHANNELS(2), .WINDOW_LENGTH(2)) u_b (
        .clk(clk), .rst(b_rst), .ena(b_ena), .din(b_din), .thresh(b_thr),
        .peak_valid(b_valid), .peak_chan(b_chan), .peak_index(b_idx),
        .peak_value(b_val), .peak_hit(b_hit)
    );

    peak_detect #(.DATA_WIDTH(16), .NUM_CHANNELS(3), .WINDOW_LENGTH(2)) u_c (
        .clk(clk), .rst(c_rst), .ena(c_ena), .din(c_din), .thresh(c_thr),
        .peak_valid(c_valid), .peak_chan(c_chan), .peak_index(c_idx),
        .peak_value(c_val), .peak_hit(c_hit)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse cycles compare against the queue head, quiet cycles against the last result.
    task automatic mon(input string tag, input exp_t head, inout exp_t last, output bit pop,
                       input logic v, input logic [31:0] ch, input logic [31:0] ix,
                       input logic [31:0] vl, input logic hh);
        pop = (head.due == neg_cnt);
        check({tag, "_valid"}, 32'(v), 32'(pop));
        if (pop) last = head;
        check({tag, "_chan"},  ch,       32'(last.chan));
        check({tag, "_index"}, ix,       32'(last.idx));
        check({tag, "_value"}, vl,       32'(last.val));
        check({tag, "_hit"},   32'(hh),  32'(last.hit));
    endtask

    always @(negedge clk) begin
        exp_t h;
        bit   pop;
        neg_cnt++;
        if (mon_en) begin
            h = '{due: -1, chan: 0, idx: 0, val: 0, hit: 0};
            if (q_a.size() > 0) h = q_a[0];
            mon("A", h, l_a, pop, a_valid, 32'(a_chan), 32'(a_idx), 32'(a_val), a_hit);
            if (pop) void'(q_a.pop_front());

            h = '{due: -1, chan: 0, idx: 0, val: 0, hit: 0};
            if (q_b.size() > 0) h = q_b[0];
            mon("B", h, l_b, pop, b_valid, 32'(b_chan), 32'(b_idx), 32'(b_val), b_hit);
            if (pop) void'(q_b.pop_front());

            h = '{due: -1, chan: 0, idx: 0, val: 0, hit: 0};
            if (q_c.size() > 0) h = q_c[0];
            mon("C", h, l_c, pop, c_valid, 32'(c_chan), 32'(c_idx), 32'(c_val), c_hit);
            if (pop) void'(q_c.pop_front());
        end
    end

    // Result is due two negedges after the final sample is driven.
    task automatic push(input int which, input int ch, input int ix, input int vl, input int hh);
        exp_t e;
        e = '{due: neg_cnt + 2, chan: ch, idx: ix, val: vl, hit: hh};
        if (which == 0) q_a.push_back(e);
        else if (which == 1) q_b.push_back(e);
        else q_c.push_back(e);
    endtask

    task automatic step(input int which, input bit e, input logic [15:0] d);
        a_ena = (which == 0) && e;
        b_ena = (which == 1) && e;
        c_ena = (which == 2) && e;
        a_din = d;
        b_din = d;
        c_din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1'b0, 16'hA5A5);
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_ena = 1'b0; b_ena = 1'b0; c_ena = 1'b0;
        a_din = '0;   b_din = '0;   c_din = '0;
        a_thr = '0;   b_thr = '0;   c_thr = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        l_a = '{due: 0, chan: 0, idx: 0, val: 0, hit: 0};
        l_b = l_a;
        l_c = l_a;
        mon_en = 1'b1;
        idle(2);

        // Basic window with a tie: earliest 9 wins, below threshold
        a_thr = 16'd10;
        step(0, 1, 16'd3); step(0, 1, 16'd9); step(0, 1, 16'd7);
        push(0, 0, 1, 9, 0); step(0, 1, 16'd9);

        // Maximum at index 0 equal to threshold, then a fresh window
        a_thr = 16'd20;
        step(0, 1, 16'd20); step(0, 1, 16'd0); step(0, 1, 16'd0);
        push(0, 0, 0, 20, 1); step(0, 1, 16'd0);
        step(0, 1, 16'd1); step(0, 1, 16'd2); step(0, 1, 16'd3);
        push(0, 0, 3, 4, 0); step(0, 1, 16'd4);
        idle(2);

        // Same window with ena gaps carrying junk on din
        a_thr = 16'd10;
        step(0, 1, 16'd3); idle(5);
        step(0, 1, 16'd9); idle(5);
        step(0, 1, 16'd7); idle(5);
        push(0, 0, 1, 9, 0); step(0, 1, 16'd9);
        idle(4);

        // All-equal window and full-scale final sample
        a_thr = 16'd7;
        step(0, 1, 16'd7); step(0, 1, 16'd7); step(0, 1, 16'd7);
        push(0, 0, 0, 7, 1); step(0, 1, 16'd7);
        a_thr = 16'hFFFF;
        step(0, 1, 16'd1); step(0, 1, 16'd0); step(0, 1, 16'd2);
        push(0, 0, 3, 16'hFFFF, 1); step(0, 1, 16'hFFFF);
        idle(2);

        // Reset mid-window (with ena high) discards the partial window
        a_thr = 16'd10;
        step(0, 1, 16'd50); step(0, 1, 16'd60);
        a_rst = 1'b1;
        step(0, 1, 16'hDEAD);
        a_rst = 1'b0;
        l_a = '{due: 0, chan: 0, idx: 0, val: 0, hit: 0};
        idle(1);
        step(0, 1, 16'd1); step(0, 1, 16'd2); step(0, 1, 16'd3);
        push(0, 0, 3, 4, 0); step(0, 1, 16'd4);
        idle(3);

        // Two channels, results on consecutive cycles
        b_thr = 16'd3;
        step(1, 1, 16'd5); step(1, 1, 16'd1);
        push(1, 0, 1, 8, 1); step(1, 1, 16'd8);
        push(1, 1, 1, 2, 0); step(1, 1, 16'd2);
        idle(3);

        // Three channels, threshold raised on chan1's final sample
        c_thr = 16'd0;
        step(2, 1, 16'd4); step(2, 1, 16'd5); step(2, 1, 16'd6);
        push(2, 0, 1, 7, 1); step(2, 1, 16'd7);
        c_thr = 16'hFFFF;
        push(2, 1, 0, 5, 0); step(2, 1, 16'd3);
        push(2, 2, 1, 9, 0); step(2, 1, 16'd9);
        idle(4);

        check("A_pending", 32'(q_a.size()), 32'd0);
        check("B_pending", 32'(q_b.size()), 32'd0);
        check("C_pending", 32'(q_c.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
